// File: rtl/alu_issue_ctrl_if.sv
// alu_issue_ctrl_if: request, ALU drive and response signals of the ALU issue controller
interface alu_issue_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic [7:0]  req_a;
    logic [7:0]  req_b;
    logic [3:0]  req_cmd;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [3:0]  alu_cmd;
    logic        alu_oe;
    logic [15:0] alu_d;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic [3:0]  rsp_cmd;
    modport master (
        output req_valid, req_a, req_b, req_cmd, alu_d, rsp_ready,
        input  req_ready, alu_a, alu_b, alu_cmd, alu_oe, rsp_valid, rsp_data, rsp_cmd
    );
    modport slave (
        input  req_valid, req_a, req_b, req_cmd, alu_d, rsp_ready,
        output req_ready, alu_a, alu_b, alu_cmd, alu_oe, rsp_valid, rsp_data, rsp_cmd
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: queues ALU requests, drives one per DRIVE cycle and holds the result until accepted
module alu_issue_ctrl #(
    parameter int DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   resetn,
    alu_issue_ctrl_if.slave        bus,
    output logic [$clog2(DEPTH):0] fifo_count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    typedef enum logic [1:0] {IDLE, DRIVE, HOLD} state_t;
    state_t state, state_nx;
    logic [19:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [19:0] head;
    logic push, pop;
    assign head = mem[rp];
    assign push = bus.req_valid && bus.req_ready;
    assign pop = state == DRIVE;
    // ready depends only on the registered count, so a pop never raises it combinationally
    assign bus.req_ready = fifo_count != FULL;
    always_ff @(posedge clock) begin
        if (push) mem[wp] <= {bus.req_a, bus.req_b, bus.req_cmd};
    end
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else state <= state_nx;
    end
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wp <= '0;
            rp <= '0;
            fifo_count <= '0;
            bus.rsp_data <= '0;
            bus.rsp_cmd <= '0;
        end else begin
            if (push) wp <= wp + AW'(1);
            if (pop) rp <= rp + AW'(1);
            fifo_count <= fifo_count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
            if (pop) begin
                bus.rsp_data <= bus.alu_d;
                bus.rsp_cmd <= head[3:0];
            end
        end
    end
    // leaving HOLD counts this edge's push so a just-arrived request is driven without an IDLE bubble
    always_comb begin
        state_nx = state == IDLE  ? (fifo_count != '0 ? DRIVE : IDLE)
                 : state == DRIVE ? HOLD
                 : bus.rsp_ready  ? (fifo_count != '0 || push ? DRIVE : IDLE) : HOLD;
        bus.alu_oe = pop;
        bus.alu_a = pop ? head[19:12] : '0;
        bus.alu_b = pop ? head[11:4] : '0;
        bus.alu_cmd = pop ? head[3:0] : '0;
        bus.rsp_valid = state == HOLD;
    end
endmodule
